// File: rtl/byte_pack_32_wr.sv
// rtl/byte_pack_32_wr.sv - packs a line-marked byte stream into padded 32-bit FIFO words
module byte_pack_32_wr #(
   parameter logic [7:0] PAD_BYTE   = 8'h00,
   parameter int         BYTE_ORDER = 0,
   parameter int         WCNT_W     = 12
) (
   input  logic              wclk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic [7:0]        din,
   input  logic              din_vld,
   input  logic              line_end,
   input  logic              wfull,
   output logic [31:0]       wdata,
   output logic              wen,
   output logic              line_done,
   output logic [WCNT_W-1:0] line_words,
   output logic              overflow,
   output logic [15:0]       drop_cnt,
   input  logic              ovf_clr
);

   logic [1:0]        idx;
   logic [31:0]       acc;
   logic [WCNT_W-1:0] line_cnt;

   logic [1:0]        idx_eff;
   logic [31:0]       acc_eff;
   logic [WCNT_W-1:0] cnt_eff;
   logic [31:0]       acc_next;
   logic [31:0]       word_pad;
   logic              complete;
   logic              drop;

   // frame_start discards the partial word, so the incoming byte sees a fresh packer
   always_comb begin
      idx_eff  = frame_start ? 2'd0 : idx;
      acc_eff  = frame_start ? 32'd0 : acc;
      cnt_eff  = frame_start ? '0 : line_cnt;
      acc_next = acc_eff;
      word_pad = 32'd0;
      for (int k = 0; k < 4; k++) begin
         if (k == int'(idx_eff))
            acc_next[(((BYTE_ORDER != 0) ? (3 - k) : k) * 8) +: 8] = din;
      end
      word_pad = acc_next;
      for (int k = 0; k < 4; k++) begin
         if (k > int'(idx_eff))
            word_pad[(((BYTE_ORDER != 0) ? (3 - k) : k) * 8) +: 8] = PAD_BYTE;
      end
      complete = din_vld && ((idx_eff == 2'd3) || line_end);
      drop     = complete && wfull;
   end

   // byte index and accumulator: restart after every completed word
   always_ff @(posedge wclk or posedge reset) begin
      if (reset) begin
         idx <= 2'd0;
         acc <= 32'd0;
      end else if (complete) begin
         idx <= 2'd0;
         acc <= 32'd0;
      end else if (din_vld) begin
         idx <= idx_eff + 2'd1;
         acc <= acc_next;
      end else if (frame_start) begin
         idx <= 2'd0;
         acc <= 32'd0;
      end
   end

   // per-line word counter; dropped words still count
   always_ff @(posedge wclk or posedge reset) begin
      if (reset) begin
         line_cnt   <= '0;
         line_words <= '0;
      end else if (complete) begin
         if (line_end) begin
            line_cnt   <= '0;
            line_words <= cnt_eff + WCNT_W'(1);
         end else begin
            line_cnt <= cnt_eff + WCNT_W'(1);
         end
      end else if (frame_start) begin
         line_cnt <= '0;
      end
   end

   // FIFO write port, one cycle behind completion; wdata holds when nothing is written
   always_ff @(posedge wclk or posedge reset) begin
      if (reset) begin
         wdata     <= 32'd0;
         wen       <= 1'b0;
         line_done <= 1'b0;
      end else begin
         wen       <= complete && !wfull;
         line_done <= complete && line_end;
         if (complete && !wfull)
            wdata <= word_pad;
      end
   end

   // sticky overflow and saturating drop count; a new drop beats a clear
   always_ff @(posedge wclk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
         drop_cnt <= 16'd0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (ovf_clr)
            drop_cnt <= 16'd1;
         else if (drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
         drop_cnt <= 16'd0;
      end
   end

endmodule

// File: tb/tb_byte_pack_32_wr.sv
// tb/tb_byte_pack_32_wr.sv - directed bench for byte_pack_32_wr
module tb_byte_pack_32_wr;

   logic        wclk = 1'b0;
   logic        reset;
   logic        frame_start, din_vld, line_end, wfull, ovf_clr;
   logic [7:0]  din;
   logic [31:0] wdata0, wdata1;
   logic        wen0, wen1, line_done0, line_done1, overflow0, overflow1;
   logic [11:0] line_words0, line_words1;
   logic [15:0] drop_cnt0, drop_cnt1;

   int total = 0;
   int bad   = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] lw[$];
   int          ldpos[$];

   always #5 wclk = ~wclk;

   byte_pack_32_wr #(.PAD_BYTE(8'h00), .BYTE_ORDER(0), .WCNT_W(12)) dut0 (
      .wclk(wclk), .reset(reset), .frame_start(frame_start), .din(din),
      .din_vld(din_vld), .line_end(line_end), .wfull(wfull), .wdata(wdata0),
      .wen(wen0), .line_done(line_done0), .line_words(line_words0),
      .overflow(overflow0), .drop_cnt(drop_cnt0), .ovf_clr(ovf_clr)
   );

   byte_pack_32_wr #(.PAD_BYTE(8'h00), .BYTE_ORDER(1), .WCNT_W(12)) dut1 (
      .wclk(wclk), .reset(reset), .frame_start(frame_start), .din(din),
      .din_vld(din_vld), .line_end(line_end), .wfull(wfull), .wdata(wdata1),
      .wen(wen1), .line_done(line_done1), .line_words(line_words1),
      .overflow(overflow1), .drop_cnt(drop_cnt1), .ovf_clr(ovf_clr)
   );

   // collect written words and line completions
   always @(negedge wclk) begin
      if (wen0) q0.push_back(wdata0);
      if (wen1) q1.push_back(wdata1);
      if (line_done0) begin
         lw.push_back({20'd0, line_words0});
         ldpos.push_back(q0.size());
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [7:0] b, input logic le,
                        input logic fs, input logic full, input logic clr);
      @(negedge wclk);
      din_vld = vld; din = b; line_end = le; frame_start = fs; wfull = full; ovf_clr = clr;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clear_q();
      q0.delete(); q1.delete(); lw.delete(); ldpos.delete();
   endtask

   initial begin
      reset = 1'b1;
      din_vld = 0; din = 0; line_end = 0; frame_start = 0; wfull = 0; ovf_clr = 0;
      repeat (3) @(negedge wclk);
      check("rst_wdata", wdata0, 32'd0);
      check("rst_wen", {31'd0, wen0}, 32'd0);
      check("rst_line_done", {31'd0, line_done0}, 32'd0);
      check("rst_line_words", {20'd0, line_words0}, 32'd0);
      check("rst_overflow", {31'd0, overflow0}, 32'd0);
      check("rst_drop_cnt", {16'd0, drop_cnt0}, 32'd0);
      reset = 1'b0;
      idle(2);
      clear_q();

      // 8 bytes, two full words
      for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), i == 8, 1'b0, 1'b0, 1'b0);
      idle(3);
      check("t1_nwords", q0.size(), 2);
      if (q0.size() == 2) begin
         check("t1_w0", q0[0], 32'h04030201);
         check("t1_w1", q0[1], 32'h08070605);
      end
      check("t1_ndone", lw.size(), 1);
      if (lw.size() == 1) begin
         check("t1_line_words", lw[0], 32'd2);
         check("t1_done_pos", ldpos[0], 2);
      end
      clear_q();

      // 5 bytes, padded tail
      drive(1'b1, 8'hAA, 0, 0, 0, 0);
      drive(1'b1, 8'hBB, 0, 0, 0, 0);
      drive(1'b1, 8'hCC, 0, 0, 0, 0);
      drive(1'b1, 8'hDD, 0, 0, 0, 0);
      drive(1'b1, 8'hEE, 1, 0, 0, 0);
      idle(3);
      check("t2_nwords", q0.size(), 2);
      if (q0.size() == 2) begin
         check("t2_w0", q0[0], 32'hDDCCBBAA);
         check("t2_w1", q0[1], 32'h000000EE);
      end
      check("t2_ndone", lw.size(), 1);
      if (lw.size() == 1) check("t2_line_words", lw[0], 32'd2);
      clear_q();

      // big-endian lane order on dut1
      drive(1'b1, 8'h11, 0, 0, 0, 0);
      drive(1'b1, 8'h22, 0, 0, 0, 0);
      drive(1'b1, 8'h33, 1, 0, 0, 0);
      idle(3);
      check("t3_nwords", q1.size(), 1);
      if (q1.size() == 1) check("t3_w0", q1[0], 32'h11223300);
      clear_q();

      // 12-byte line with wfull across the 2nd completion
      for (int i = 1; i <= 12; i++) drive(1'b1, 8'(i), i == 12, 1'b0, i == 8, 1'b0);
      idle(3);
      check("t4_nwords", q0.size(), 2);
      if (q0.size() == 2) begin
         check("t4_w0", q0[0], 32'h04030201);
         check("t4_w1", q0[1], 32'h0C0B0A09);
      end
      check("t4_overflow", {31'd0, overflow0}, 32'd1);
      check("t4_drop_cnt", {16'd0, drop_cnt0}, 32'd1);
      if (lw.size() == 1) check("t4_line_words", lw[0], 32'd3);
      else check("t4_ndone", lw.size(), 1);
      // drop coincident with clear: set wins
      for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), i == 4, 1'b0, i == 4, i == 4);
      idle(3);
      check("t4_setwins_ovf", {31'd0, overflow0}, 32'd1);
      check("t4_setwins_cnt", {16'd0, drop_cnt0}, 32'd1);
      drive(1'b0, 8'h00, 0, 0, 0, 1);
      idle(3);
      check("t4_clr_ovf", {31'd0, overflow0}, 32'd0);
      check("t4_clr_cnt", {16'd0, drop_cnt0}, 32'd0);
      clear_q();

      // partial word discarded by frame_start
      drive(1'b1, 8'hE1, 0, 0, 0, 0);
      drive(1'b1, 8'hE2, 0, 0, 0, 0);
      drive(1'b1, 8'hE3, 0, 0, 0, 0);
      drive(1'b0, 8'h00, 0, 1, 0, 0);
      for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      check("t5_nwords", q0.size(), 1);
      if (q0.size() == 1) check("t5_w0", q0[0], 32'h04030201);
      check("t5_ndone", lw.size(), 0);
      clear_q();

      // frame_start together with a line_end byte
      drive(1'b1, 8'hC1, 0, 0, 0, 0);
      drive(1'b1, 8'hC2, 0, 0, 0, 0);
      drive(1'b1, 8'h5A, 1, 1, 0, 0);
      idle(3);
      check("t6_nwords", q0.size(), 1);
      if (q0.size() == 1) check("t6_w0", q0[0], 32'h0000005A);
      if (lw.size() == 1) check("t6_line_words", lw[0], 32'd1);
      else check("t6_ndone", lw.size(), 1);
      clear_q();

      // back-to-back single-byte lines
      for (int i = 0; i < 4; i++) drive(1'b1, 8'hA1 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      check("t7_nwords", q0.size(), 4);
      check("t7_ndone", lw.size(), 4);
      if (q0.size() == 4 && lw.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("t7_w%0d", i), q0[i], {24'd0, 8'hA1 + 8'(i)});
            check($sformatf("t7_lw%0d", i), lw[i], 32'd1);
            check($sformatf("t7_pos%0d", i), ldpos[i], i + 1);
         end
      end
      clear_q();

      // reset in the middle of a line clears the partial word
      drive(1'b1, 8'hF1, 0, 0, 0, 0);
      drive(1'b1, 8'hF2, 0, 0, 0, 0);
      @(negedge wclk);
      din_vld = 0; reset = 1'b1;
      @(negedge wclk);
      reset = 1'b0;
      for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), i == 4, 1'b0, 1'b0, 1'b0);
      idle(3);
      check("t8_nwords", q0.size(), 1);
      if (q0.size() == 1) check("t8_w0", q0[0], 32'h04030201);
      if (lw.size() == 1) check("t8_line_words", lw[0], 32'd1);
      else check("t8_ndone", lw.size(), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
